// File: rtl/macc_frame_feeder.sv
// Feeds the dual-stream MACC: samples go out on A with frame tlast; matching coefficients
// stream on B from a writable table. An A-to-B credit count keeps B at or behind A.
module macc_frame_feeder #(
  parameter int ADW   = 24,
  parameter int BDW   = 18,
  parameter int NCOEF = 64,
  parameter int AW    = $clog2(NCOEF),
  parameter int LW    = $clog2(NCOEF + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic signed [ADW-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic signed [ADW-1:0] m_axis_atdata,
  output logic                  m_axis_atvalid,
  input  logic                  m_axis_atready,
  output logic                  m_axis_atlast,
  output logic signed [BDW-1:0] m_axis_btdata,
  output logic                  m_axis_btvalid,
  input  logic                  m_axis_btready,
  output logic                  m_axis_btlast,
  input  logic                  coef_wr_en,
  input  logic [AW-1:0]         coef_wr_addr,
  input  logic signed [BDW-1:0] coef_wr_data,
  input  logic [LW-1:0]         frame_len,
  output logic                  cfg_busy
);

  function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] req);
    logic [LW-1:0] res;
    res = req;
    if (req == '0) res = LW'(1);
    else if (req > LW'(NCOEF)) res = LW'(NCOEF);
    return res;
  endfunction

  function automatic logic [AW-1:0] next_idx(input logic [AW-1:0] idx, input logic last);
    return last ? '0 : idx + AW'(1);
  endfunction

  logic signed [BDW-1:0] r_coef_mem [NCOEF];

  logic signed [ADW-1:0] r_a_data_p0, r_a_data_p1;
  logic                  r_a_vld_p0, r_a_vld_p1;
  logic                  r_a_last_p0, r_a_last_p1;
  logic signed [BDW-1:0] r_b_data_p1;
  logic                  r_b_vld_p1, r_b_last_p1;
  logic [AW-1:0]         r_a_idx, r_b_idx;
  logic [LW-1:0]         r_credits, r_len;
  logic                  r_cfg_busy;

  logic [LW-1:0] w_len_req, w_len_last;
  logic          w_a_last, w_b_last, w_cfg_block, w_s_ready, w_s_acc;
  logic          w_a_pop, w_b_pop, w_b_avail, w_b_issue, w_drained, w_coef_we;

  assign w_len_req   = clamp_len(frame_len);
  assign w_len_last  = r_len - LW'(1);
  assign w_a_last    = (LW'(r_a_idx) == w_len_last);
  assign w_b_last    = (LW'(r_b_idx) == w_len_last);
  // A pending length change closes the sample gate only once the current A frame is complete.
  assign w_cfg_block = r_cfg_busy && (r_a_idx == '0);
  assign w_s_ready   = !rst && !r_a_vld_p0 && (r_credits < LW'(NCOEF)) && !w_cfg_block;
  assign w_s_acc     = s_axis_tvalid && w_s_ready;
  assign w_a_pop     = r_a_vld_p1 && m_axis_atready;
  assign w_b_pop     = r_b_vld_p1 && m_axis_btready;
  // Credits not yet represented by the beat sitting in the B output register.
  assign w_b_avail   = r_credits > {{(LW-1){1'b0}}, r_b_vld_p1};
  assign w_b_issue   = w_b_avail && (!r_b_vld_p1 || m_axis_btready);
  assign w_drained   = (r_a_idx == '0) && (r_b_idx == '0) && (r_credits == '0) &&
                       !r_a_vld_p0 && !r_a_vld_p1 && !r_b_vld_p1;
  assign w_coef_we   = coef_wr_en && (int'(coef_wr_addr) < NCOEF);

  // Stage p0 (A skid slot) -> p1 (A/B output registers): control
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_vld_p0  <= 1'b0;
      r_a_last_p0 <= 1'b0;
      r_a_vld_p1  <= 1'b0;
      r_a_last_p1 <= 1'b0;
      r_b_vld_p1  <= 1'b0;
      r_b_last_p1 <= 1'b0;
      r_a_idx     <= '0;
      r_b_idx     <= '0;
      r_credits   <= '0;
      r_cfg_busy  <= 1'b0;
      r_len       <= w_len_req;
    end else begin
      if (w_a_pop || !r_a_vld_p1) begin
        if (r_a_vld_p0) begin
          r_a_vld_p1  <= 1'b1;
          r_a_last_p1 <= r_a_last_p0;
          r_a_vld_p0  <= 1'b0;
          r_a_last_p0 <= 1'b0;
        end else begin
          r_a_vld_p1  <= w_s_acc;
          r_a_last_p1 <= w_s_acc && w_a_last;
        end
      end else if (w_s_acc) begin
        r_a_vld_p0  <= 1'b1;
        r_a_last_p0 <= w_a_last;
      end

      if (w_s_acc) r_a_idx <= next_idx(r_a_idx, w_a_last);

      if (w_b_issue) begin
        r_b_vld_p1  <= 1'b1;
        r_b_last_p1 <= w_b_last;
        r_b_idx     <= next_idx(r_b_idx, w_b_last);
      end else if (w_b_pop) begin
        r_b_vld_p1  <= 1'b0;
        r_b_last_p1 <= 1'b0;
      end

      case ({w_s_acc, w_b_pop})
        2'b10:   r_credits <= r_credits + LW'(1);
        2'b01:   r_credits <= r_credits - LW'(1);
        default: r_credits <= r_credits;
      endcase

      if (r_cfg_busy && w_drained) begin
        r_len      <= w_len_req;
        r_cfg_busy <= 1'b0;
      end else begin
        r_cfg_busy <= (w_len_req != r_len);
      end
    end
  end

  // Stage p0 -> p1: data path and coefficient table (read-before-write on the same address)
  always_ff @(posedge clk) begin
    if (w_a_pop || !r_a_vld_p1) begin
      if (r_a_vld_p0) r_a_data_p1 <= r_a_data_p0;
      else if (w_s_acc) r_a_data_p1 <= s_axis_tdata;
    end else if (w_s_acc) begin
      r_a_data_p0 <= s_axis_tdata;
    end
    if (w_b_issue) r_b_data_p1 <= r_coef_mem[r_b_idx];
    if (w_coef_we) r_coef_mem[coef_wr_addr] <= coef_wr_data;
  end

  assign s_axis_tready  = w_s_ready;
  assign m_axis_atdata  = r_a_data_p1;
  assign m_axis_atvalid = r_a_vld_p1;
  assign m_axis_atlast  = r_a_last_p1;
  assign m_axis_btdata  = r_b_data_p1;
  assign m_axis_btvalid = r_b_vld_p1;
  assign m_axis_btlast  = r_b_last_p1;
  assign cfg_busy       = r_cfg_busy;

endmodule
